// File: rtl/riscv_cache_dm.sv
// Direct-mapped, one-word-per-line data cache between the processor port and main memory.
// WRITE_BACK selects write-back/allocate or write-through/no-allocate; flush drains and invalidates.
module riscv_cache_dm #(
  parameter int NUM_LINES  = 16,
  parameter bit WRITE_BACK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreq_val,
  output logic        memreq_rdy,
  input  logic [66:0] memreq_msg,
  output logic        memresp_val,
  input  logic        memresp_rdy,
  output logic [34:0] memresp_msg,
  output logic        cachereq_val,
  input  logic        cachereq_rdy,
  output logic [66:0] cachereq_msg,
  input  logic        cacheresp_val,
  output logic        cacheresp_rdy,
  input  logic [34:0] cacheresp_msg,
  input  logic        flush,
  output logic        flush_done,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 30 - IDX_W;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_t;

  typedef enum logic [3:0] {
    IDLE, TAG_CHECK, EVICT_REQ, EVICT_WAIT, REFILL_REQ, REFILL_WAIT,
    WT_REQ, WT_WAIT, RESP, FL_SCAN, FL_REQ, FL_WAIT, FL_DONE
  } state_t;

  state_t               state, miss_next;
  mem_req_t             req_q, creq_q, miss_req, refill_req, wt_req, fl_req;
  logic [31:0]          resp_data;
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];
  logic [IDX_W-1:0]     scan_idx, idx;
  logic [TAG_W-1:0]     tag;
  logic                 hit, scan_last;
  logic                 unused_bits;

  assign idx       = req_q.addr[IDX_W+1:2];
  assign tag       = req_q.addr[31:IDX_W+2];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign scan_last = (scan_idx == IDX_W'(NUM_LINES - 1));
  assign unused_bits = ^{cacheresp_msg[34:32], req_q.addr[1:0]};

  assign refill_req = '{wr: 1'b0, addr: {req_q.addr[31:2], 2'b00}, len: 2'b00, data: 32'd0};
  assign wt_req     = '{wr: 1'b1, addr: {req_q.addr[31:2], 2'b00}, len: 2'b00, data: req_q.data};
  assign fl_req     = '{wr: 1'b1, addr: {tag_q[scan_idx], scan_idx, 2'b00}, len: 2'b00,
                        data: data_q[scan_idx]};

  // A dirty victim must be written out before the refill read is issued.
  always_comb begin
    miss_req  = refill_req;
    miss_next = REFILL_REQ;
    if (valid_q[idx] && dirty_q[idx]) begin
      miss_req  = '{wr: 1'b1, addr: {tag_q[idx], idx, 2'b00}, len: 2'b00, data: data_q[idx]};
      miss_next = EVICT_REQ;
    end
  end

  assign memreq_rdy    = (state == IDLE) && !flush;
  assign memresp_val   = (state == RESP);
  assign memresp_msg   = {req_q.wr, req_q.len, req_q.wr ? 32'd0 : resp_data};
  assign cachereq_val  = state inside {EVICT_REQ, REFILL_REQ, WT_REQ, FL_REQ};
  assign cachereq_msg  = creq_q;
  assign cacheresp_rdy = state inside {EVICT_WAIT, REFILL_WAIT, WT_WAIT, FL_WAIT};
  assign flush_done    = (state == FL_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      scan_idx   <= '0;
      req_q      <= '0;
      creq_q     <= '0;
      resp_data  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (flush) begin
            scan_idx <= '0;
            state    <= FL_SCAN;
          end else if (memreq_val) begin
            req_q <= memreq_msg;
            state <= TAG_CHECK;
          end
        end
        TAG_CHECK: begin
          if (hit) hit_count  <= hit_count + 32'd1;
          else     miss_count <= miss_count + 32'd1;
          if (hit && !req_q.wr) begin
            resp_data <= data_q[idx];
            state     <= RESP;
          end else if (hit) begin
            data_q[idx] <= req_q.data;
            if (WRITE_BACK) begin
              dirty_q[idx] <= 1'b1;
              state        <= RESP;
            end else begin
              creq_q <= wt_req;
              state  <= WT_REQ;
            end
          end else if (req_q.wr && !WRITE_BACK) begin
            creq_q <= wt_req;
            state  <= WT_REQ;
          end else begin
            creq_q <= miss_req;
            state  <= miss_next;
          end
        end
        EVICT_REQ:  if (cachereq_rdy) state <= EVICT_WAIT;
        EVICT_WAIT: if (cacheresp_val) begin
          creq_q <= refill_req;
          state  <= REFILL_REQ;
        end
        REFILL_REQ:  if (cachereq_rdy) state <= REFILL_WAIT;
        REFILL_WAIT: if (cacheresp_val) begin
          valid_q[idx] <= 1'b1;
          tag_q[idx]   <= tag;
          if (req_q.wr) begin
            data_q[idx]  <= req_q.data;
            dirty_q[idx] <= 1'b1;
          end else begin
            data_q[idx]  <= cacheresp_msg[31:0];
            dirty_q[idx] <= 1'b0;
            resp_data    <= cacheresp_msg[31:0];
          end
          state <= RESP;
        end
        WT_REQ:  if (cachereq_rdy) state <= WT_WAIT;
        WT_WAIT: if (cacheresp_val) state <= RESP;
        RESP:    if (memresp_rdy) state <= IDLE;
        FL_SCAN: begin
          valid_q[scan_idx] <= 1'b0;
          if (WRITE_BACK && valid_q[scan_idx] && dirty_q[scan_idx]) begin
            creq_q <= fl_req;
            state  <= FL_REQ;
          end else if (scan_last) begin
            state <= FL_DONE;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
          end
        end
        FL_REQ:  if (cachereq_rdy) state <= FL_WAIT;
        FL_WAIT: if (cacheresp_val) begin
          dirty_q[scan_idx] <= 1'b0;
          if (scan_last) begin
            state <= FL_DONE;
          end else begin
            scan_idx <= scan_idx + IDX_W'(1);
            state    <= FL_SCAN;
          end
        end
        FL_DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/riscv_cache_dm.md
Name: riscv_cache_dm

Overview:
- Parametrised direct-mapped, one-word-per-line data cache.
- Sits between the processor data-memory port (memreq/memresp) and main memory (cachereq/cacheresp).
- Write mode is selectable: write-back/write-allocate or write-through/no-write-allocate.
- Provides a flush handshake that drains dirty lines to memory and invalidates the array. Hit and miss counters support lab measurements.

Parameters:
- NUM_LINES, 16, number of lines; power of two, 2..256. IDX_W = log2(NUM_LINES).
- WRITE_BACK, 1, 1 = write-back + write-allocate; 0 = write-through + no-write-allocate.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- memreq_val  in  1  processor request valid
- memreq_rdy  out  1  cache can accept a processor request
- memreq_msg  in  `VC_MEM_REQ_MSG_SZ(32,32)  [66] type (0 rd, 1 wr), [65:34] addr, [33:32] len, [31:0] data
- memresp_val  out  1  response to processor valid
- memresp_rdy  in  1  processor accepts response
- memresp_msg  out  `VC_MEM_RESP_MSG_SZ(32)  [34] type, [33:32] len, [31:0] data
- cachereq_val  out  1  request to main memory valid
- cachereq_rdy  in  1  memory accepts request
- cachereq_msg  out  `VC_MEM_REQ_MSG_SZ(32,32)  same layout as memreq_msg; len always 0
- cacheresp_val  in  1  memory response valid
- cacheresp_rdy  out  1  cache accepts memory response
- cacheresp_msg  in  `VC_MEM_RESP_MSG_SZ(32)  memory response
- flush  in  1  flush request, sampled in IDLE
- flush_done  out  1  one-cycle pulse when flush completes
- hit_count  out  32  reads + writes that hit
- miss_count  out  32  accesses that miss

Behaviour:
Address and array:
- Word accesses only. len is echoed in the response; addr[1:0] is ignored.
- idx = addr[IDX_W+1:2]; tag = addr[31:IDX_W+2].
- Per-line state: valid, dirty (WRITE_BACK only), tag, data.

Reset:
- All valid and dirty bits cleared; counters cleared; state = IDLE.
- All val outputs 0; flush_done 0; memreq_rdy 1.
- Reset mid-transaction abandons the transaction; no memory request is re-issued.

States: IDLE, TAG_CHECK, EVICT_REQ, EVICT_WAIT, REFILL_REQ, REFILL_WAIT, WT_REQ, WT_WAIT, RESP, FL_SCAN, FL_REQ, FL_WAIT, FL_DONE.

IDLE:
- memreq_rdy = 1 only here.
- If flush = 1, go to FL_SCAN with scan index 0; memreq_rdy is forced to 0 that cycle, so flush wins over a simultaneous request.
- Otherwise, on val && rdy, latch the message and go to TAG_CHECK.

TAG_CHECK:
- hit = valid[idx] && tag match. Increment exactly one counter per access.
- Read hit: go to RESP with the line data.
- Write hit, WB: update data, set dirty, go to RESP.
- Write hit, WT: update data, go to WT_REQ.
- Write miss, WT: go to WT_REQ; no allocate.
- Read miss, or write miss in WB:
  - valid && dirty: go to EVICT_REQ.
  - otherwise: go to REFILL_REQ.

EVICT_REQ / EVICT_WAIT:
- Write the old line: addr = {old tag, idx, 2'b00}.
- cachereq_val holds until cachereq_rdy; message stays stable while val = 1.
- Wait in EVICT_WAIT for cacheresp_val (cacheresp_rdy = 1 in all *_WAIT states, 0 elsewhere), then go to REFILL_REQ.

REFILL_REQ / REFILL_WAIT:
- Read the word-aligned requested address.
- On response, install the line: valid = 1, new tag.
- Read: data = response, dirty = 0.
- Write (WB): data = write data, dirty = 1.
- Go to RESP.

WT_REQ / WT_WAIT:
- Forward the write to memory, wait for the response, go to RESP.

RESP:
- memresp_val = 1 with {type, len, data}; write responses carry data 0.
- Hold until memresp_rdy, then go to IDLE.

Latency:
- Hit: response valid in the 2nd cycle after acceptance.
- Clean miss: 2 cycles + memory round trip.
- Back-pressure on either side stalls without loss.

Flush:
- FL_SCAN walks indices 0..NUM_LINES-1, one per cycle.
- A valid && dirty line goes to FL_REQ (write back), then FL_WAIT, then clear dirty and resume at the next index.
- Every scanned line is invalidated.
- After the last index, go to FL_DONE: flush_done = 1 for one cycle, then IDLE.
- With WRITE_BACK = 0, the scan issues no memory traffic.
- A flush asserted outside IDLE is not latched. The requester holds flush until flush_done.

Counters:
- 32-bit, wrap modulo 2^32.
- Flush accesses are not counted.

Test Plan:
- NUM_LINES = 16, WB = 1: read 0x100 (miss, memory returns 0xAAAA), then read 0x100 → second response 0xAAAA two cycles after acceptance, no cachereq; hit_count = 1, miss_count = 1.
- Write 0x104 = 0x1234 (allocate, dirty), then read 0x504 (same idx 1, tag differs) → cachereq write addr 0x104 data 0x1234, then read 0x504; response carries the memory data.
- Conflict with back-pressure: cachereq_rdy low for 5 cycles and memresp_rdy low for 3 → cachereq_msg and memresp_msg stable throughout; exactly one request issued.
- Dirty lines at idx 0, 3 and 15, then assert flush → exactly 3 memory writes in index order, flush_done single pulse; subsequent read of a flushed address misses.
- WB = 0: write hit 0x200 = 0x55 → memory write issued and cache updated, so a following read of 0x200 hits with 0x55. Write miss 0x300 → memory write only; read 0x300 then misses.
- Assert reset during REFILL_WAIT → next cycle all outputs at reset values, memreq_rdy = 1; prior hits now miss.
